// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: operation codes, ALUOp classes and the
// combinational funct-field decode used by the alu_op_decoder stage.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
   localparam logic [OP_W-1:0] OP_EQ    = 4'b1000;
   localparam logic [OP_W-1:0] OP_UNSUP = 4'b1111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      ALUOP_MEM = 2'b00,
      ALUOP_BR  = 2'b01,
      ALUOP_R   = 2'b10,
      ALUOP_I   = 2'b11
   } aluop_e;

   // Anything not explicitly listed decodes to OP_UNSUP, which the ALU maps to 0.
   function automatic logic [OP_W-1:0] alu_decode(
      input aluop_e     aluop,
      input logic [2:0] f3,
      input logic [6:0] f7
   );
      logic [OP_W-1:0] res;
      res = OP_UNSUP;
      case (aluop)
         ALUOP_MEM: res = OP_ADD;
         ALUOP_BR: begin
            if (f3 == F3_BEQ) res = OP_EQ;
         end
         ALUOP_R: begin
            if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD:  res = OP_ADD;
                  F3_AND:  res = OP_AND;
                  F3_OR:   res = OP_OR;
                  default: res = OP_UNSUP;
               endcase
            end else if (f7 == F7_ALT) begin
               if (f3 == F3_ADD) res = OP_SUB;
            end
         end
         ALUOP_I: begin
            case (f3)
               F3_ADD:  res = OP_ADD;
               F3_AND:  res = OP_AND;
               F3_OR:   res = OP_OR;
               default: res = OP_UNSUP;
            endcase
         end
         default: res = OP_UNSUP;
      endcase
      return res;
   endfunction

   function automatic logic is_unsup(input logic [OP_W-1:0] op);
      return op == OP_UNSUP;
   endfunction

endpackage

// File: rtl/alu_dec_skid.sv
// Generic 2-slot valid/ready skid buffer: OUT register plus one SKID register.
// Latency 1 cycle; in_rdy comes straight from a flop (no out_rdy combinational path).
module alu_dec_skid #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_dat,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_dat
);

   logic              out_vld_q,  out_vld_d;
   logic [DATA_W-1:0] out_dat_q,  out_dat_d;
   logic              skid_vld_q, skid_vld_d;
   logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
   logic              out_free;
   logic              in_acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         skid_vld_q <= 1'b0;
         skid_dat_q <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_dat_q  <= out_dat_d;
         skid_vld_q <= skid_vld_d;
         skid_dat_q <= skid_dat_d;
      end
   end

   always_comb begin
      out_free   = !out_vld_q || out_rdy;
      in_acc     = in_vld && !skid_vld_q;
      out_vld_d  = out_vld_q;
      out_dat_d  = out_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (out_free) begin
         // A full SKID implies in_rdy was low, so no new accept competes with it.
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_dat_d  = skid_dat_q;
            skid_vld_d = 1'b0;
         end else if (in_acc) begin
            out_vld_d = 1'b1;
            out_dat_d = in_dat;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (in_acc) begin
         skid_vld_d = 1'b1;
         skid_dat_d = in_dat;
      end
   end

   assign in_rdy  = !skid_vld_q;
   assign out_vld = out_vld_q;
   assign out_dat = out_dat_q;

endmodule

// File: rtl/alu_op_decoder.sv
// Registered ALU-control stage: (ALUOp, Funct3, Funct7) -> Operation, tag passed through.
// Optional sticky Illegal output and per-slot illegal bit enabled by ALU_DEC_ILLEGAL_EN.
module alu_op_decoder
   import alu_pkg::*;
#(
   parameter int unsigned OPCODE_LENGTH = 4,
   parameter int unsigned TAG_WIDTH     = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               ALUOp,
   input  logic [2:0]               Funct3,
   input  logic [6:0]               Funct7,
   input  logic [TAG_WIDTH-1:0]     InTag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic [TAG_WIDTH-1:0]     OutTag
`ifdef ALU_DEC_ILLEGAL_EN
   ,
   output logic                     Illegal
`endif
);

`ifdef ALU_DEC_ILLEGAL_EN
   localparam int unsigned PAY_W = OPCODE_LENGTH + TAG_WIDTH + 1;
`else
   localparam int unsigned PAY_W = OPCODE_LENGTH + TAG_WIDTH;
`endif

   logic [OP_W-1:0]          dec_raw;
   logic [OPCODE_LENGTH-1:0] dec_op;
   logic                     dec_unsup;
   logic [PAY_W-1:0]         in_pay;
   logic [PAY_W-1:0]         out_pay;

   always_comb begin
      dec_raw   = alu_decode(aluop_e'(ALUOp), Funct3, Funct7);
      dec_op    = OPCODE_LENGTH'(dec_raw);
      dec_unsup = is_unsup(dec_raw);
   end

`ifdef ALU_DEC_ILLEGAL_EN
   assign in_pay = {dec_op, InTag, dec_unsup};
`else
   assign in_pay = {dec_op, InTag};
`endif

   alu_dec_skid #(
      .DATA_W (PAY_W)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .in_vld  (in_valid),
      .in_rdy  (in_ready),
      .in_dat  (in_pay),
      .out_vld (out_valid),
      .out_rdy (out_ready),
      .out_dat (out_pay)
   );

   assign Operation = out_pay[PAY_W-1 -: OPCODE_LENGTH];
   assign OutTag    = out_pay[PAY_W-OPCODE_LENGTH-1 -: TAG_WIDTH];

`ifdef ALU_DEC_ILLEGAL_EN
   logic illegal_q, illegal_d;

   // Sticky from the accepting edge; only reset clears it.
   always_comb begin
      illegal_d = illegal_q | (in_valid && in_ready && dec_unsup);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) illegal_q <= 1'b0;
      else       illegal_q <= illegal_d;
   end

   // The OUT slot's bit is always covered by the sticky flag; OR keeps both visible.
   assign Illegal = illegal_q | (out_valid & out_pay[0]);
`else
   logic unused_unsup;
   assign unused_unsup = dec_unsup;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder (optionally with ALU_DEC_ILLEGAL_EN).
module tb_alu_op_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] ALUOp;
   logic [2:0] Funct3;
   logic [6:0] Funct7;
   logic [4:0] InTag;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] Operation;
   logic [4:0] OutTag;
`ifdef ALU_DEC_ILLEGAL_EN
   logic       Illegal;
`endif

   int checks = 0;
   int errors = 0;

   alu_op_decoder #(
      .OPCODE_LENGTH (4),
      .TAG_WIDTH     (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUOp     (ALUOp),
      .Funct3    (Funct3),
      .Funct7    (Funct7),
      .InTag     (InTag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Operation (Operation),
      .OutTag    (OutTag)
`ifdef ALU_DEC_ILLEGAL_EN
      ,
      .Illegal   (Illegal)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] tag);
      in_valid = v;
      ALUOp    = op;
      Funct3   = f3;
      Funct7   = f7;
      InTag    = tag;
   endtask

   task automatic check_out(input string name, input logic v, input logic [3:0] op,
                            input logic [4:0] tag);
      check({name, ".valid"}, 32'(out_valid), 32'(v));
      check({name, ".op"},    32'(Operation), 32'(op));
      check({name, ".tag"},   32'(OutTag),    32'(tag));
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 2'b00, 3'b000, 7'h00, 5'd0);
      #12;
      check_out("reset", 1'b0, 4'b0000, 5'd0);
      check("reset.in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_DEC_ILLEGAL_EN
      check("reset.illegal", 32'(Illegal), 32'd0);
`endif
      @(posedge clk);
      #1 reset = 1'b0;

      // Streaming, one result per cycle
      out_ready = 1'b1;
      drive(1'b1, 2'b10, 3'b000, 7'b0000000, 5'd1); tick(); check_out("s1", 1'b1, 4'b0010, 5'd1);
      drive(1'b1, 2'b10, 3'b000, 7'b0100000, 5'd2); tick(); check_out("s2", 1'b1, 4'b0110, 5'd2);
      drive(1'b1, 2'b10, 3'b111, 7'b0000000, 5'd3); tick(); check_out("s3", 1'b1, 4'b0000, 5'd3);
      drive(1'b1, 2'b10, 3'b110, 7'b0000000, 5'd4); tick(); check_out("s4", 1'b1, 4'b0001, 5'd4);
      drive(1'b1, 2'b01, 3'b000, 7'b1010101, 5'd5); tick(); check_out("s5", 1'b1, 4'b1000, 5'd5);
      drive(1'b0, 2'b00, 3'b000, 7'h00, 5'd0);      tick();
      check("s_empty.valid", 32'(out_valid), 32'd0);
`ifdef ALU_DEC_ILLEGAL_EN
      check("s.illegal", 32'(Illegal), 32'd0);
`endif

      // Backpressure: two accepted, third stalls, Operation held
      out_ready = 1'b0;
      drive(1'b1, 2'b10, 3'b111, 7'b0000000, 5'd6); tick();
      check_out("bp1", 1'b1, 4'b0000, 5'd6);
      check("bp1.in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 2'b11, 3'b110, 7'b0000000, 5'd7); tick();
      check_out("bp2", 1'b1, 4'b0000, 5'd6);
      check("bp2.in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 2'b00, 3'b000, 7'b0000000, 5'd8); tick();
      check_out("bp3", 1'b1, 4'b0000, 5'd6);
      check("bp3.in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      check_out("bp_drain7", 1'b1, 4'b0001, 5'd7);
      check("bp_drain7.in_ready", 32'(in_ready), 32'd1);
      tick();
      check_out("bp_drain8", 1'b1, 4'b0010, 5'd8);
      drive(1'b0, 2'b00, 3'b000, 7'h00, 5'd0); tick();
      check("bp_empty.valid", 32'(out_valid), 32'd0);

      // Simultaneous in/out transfer with SKID empty; I-type ignores Funct7
      out_ready = 1'b0;
      drive(1'b1, 2'b10, 3'b000, 7'b0100000, 5'd9); tick();
      check_out("sim9", 1'b1, 4'b0110, 5'd9);
      out_ready = 1'b1;
      drive(1'b1, 2'b11, 3'b000, 7'b0100000, 5'd10); tick();
      check_out("sim10", 1'b1, 4'b0010, 5'd10);
      check("sim10.in_ready", 32'(in_ready), 32'd1);

      // Unsupported encodings and load/store
      drive(1'b1, 2'b10, 3'b001, 7'b0000000, 5'd11); tick(); check_out("u11", 1'b1, 4'b1111, 5'd11);
`ifdef ALU_DEC_ILLEGAL_EN
      check("u11.illegal", 32'(Illegal), 32'd1);
`endif
      drive(1'b1, 2'b01, 3'b001, 7'b0000000, 5'd12); tick(); check_out("u12", 1'b1, 4'b1111, 5'd12);
      drive(1'b1, 2'b10, 3'b000, 7'b0000001, 5'd13); tick(); check_out("u13", 1'b1, 4'b1111, 5'd13);
      drive(1'b1, 2'b00, 3'b101, 7'b1111111, 5'd14); tick(); check_out("ls14", 1'b1, 4'b0010, 5'd14);
`ifdef ALU_DEC_ILLEGAL_EN
      check("ls14.illegal_sticky", 32'(Illegal), 32'd1);
`endif

      // Fill both slots, then reset asynchronously mid-cycle
      out_ready = 1'b0;
      drive(1'b1, 2'b11, 3'b111, 7'b0000000, 5'd15); tick();
      drive(1'b1, 2'b11, 3'b110, 7'b0000000, 5'd16); tick();
      check("full.in_ready", 32'(in_ready), 32'd0);
      drive(1'b0, 2'b00, 3'b000, 7'h00, 5'd0);
      #2 reset = 1'b1;
      #1;
      check_out("arst", 1'b0, 4'b0000, 5'd0);
      check("arst.in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_DEC_ILLEGAL_EN
      check("arst.illegal", 32'(Illegal), 32'd0);
`endif
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 2'b01, 3'b000, 7'b0000000, 5'd17); tick();
      check_out("post17", 1'b1, 4'b1000, 5'd17);
      drive(1'b0, 2'b00, 3'b000, 7'h00, 5'd0); tick();
      check("post_empty.valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Registered ALU-control stage that turns instruction-field decode (ALUOp, Funct3, Funct7) into the 4-bit `Operation` code consumed by the datapath ALU.

- Sits between the main controller and the execute stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so execute-stage stalls never drop or duplicate a decoded operation.
- Carries a tag alongside each operation so downstream logic can match results to instructions.

## Interface
Parameters:
- OPCODE_LENGTH, 4, width of the `Operation` output.
- TAG_WIDTH, 5, width of the per-operation tag passed through unchanged.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a decode request.
- in_ready  output  1  stage can accept a request this cycle.
- ALUOp  input  2  class from main controller: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- Funct3  input  3  instruction funct3.
- Funct7  input  7  instruction funct7.
- InTag  input  TAG_WIDTH  tag travelling with the request.
- out_valid  output  1  `Operation`/`OutTag` valid toward execute.
- out_ready  input  1  execute accepts the current output.
- Operation  output  OPCODE_LENGTH  ALU operation code.
- OutTag  output  TAG_WIDTH  tag of the current output.
- Illegal  output  1  present only with ALU_DEC_ILLEGAL_EN; see Configuration.

## Operation
Decode rules (pure function, evaluated on input fields):
- ALUOp 00: ADD 0010, regardless of funct fields.
- ALUOp 01: Funct3 000 gives EQ 1000; any other Funct3 is unsupported.
- ALUOp 10, Funct7 0000000: Funct3 000 ADD 0010; 111 AND 0000; 110 OR 0001; other Funct3 unsupported.
- ALUOp 10, Funct7 0100000: Funct3 000 gives SUB 0110; other Funct3 unsupported.
- ALUOp 10, any other Funct7: unsupported.
- ALUOp 11: Funct3 000 ADD, 111 AND, 110 OR; Funct7 ignored; other Funct3 unsupported.
- Unsupported: `Operation` = 1111. The ALU produces 0 for this code.

Handshake and buffering:
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Two registered slots: output register (OUT) and skid register (SKID).
- in_ready = !SKID.valid, driven directly from a flop with no combinational path from out_ready.
- On an input transfer, the decoded request goes to OUT if OUT is empty or being drained this cycle; otherwise it goes to SKID.
- On an output transfer with SKID full, SKID moves to OUT and SKID clears. If an input transfer happens in the same cycle, that cycle's accept goes to SKID only when OUT is not freed.
- Simultaneous in-transfer and out-transfer with SKID empty: OUT is reloaded with the new request; out_valid stays 1.
- While out_valid=1 && out_ready=0, `Operation`/`OutTag` hold stable (no change until transfer).
- Ordering is strict FIFO; a decode result is never lost or repeated.

## Timing
- Latency: 1 cycle. A request accepted at edge N is visible on `Operation` after edge N when OUT was free, otherwise when it reaches OUT.
- Throughput: 1 operation per cycle while out_ready=1.
- Reset values: out_valid=0, in_ready=1, Operation=0000, OutTag=0, SKID.valid=0, Illegal=0.
- Reset asserted mid-operation: both slots are discarded immediately (asynchronously) and outputs take their reset values. The first transfer is possible on the first edge after reset deasserts.
- Full: SKID.valid=1 forces in_ready=0 on the next cycle.
- Empty: out_valid=0; `Operation` holds its last value, which is don't-care to the consumer.

## Configuration
- Macro: ALU_DEC_ILLEGAL_EN.
- Defined:
  - Port `Illegal` exists. It is sticky: set on the edge that accepts an unsupported request, and cleared only by reset.
  - Each slot carries an illegal bit, and the stage also exposes it as part of OUT.
- Undefined:
  - No `Illegal` port and no per-slot illegal bit.
  - Unsupported requests still flow through with `Operation`=1111.

## Structure
- Shared package alu_pkg:
  - Operation localparams: OP_AND 0000, OP_OR 0001, OP_ADD 0010, OP_SUB 0110, OP_EQ 1000, OP_UNSUP 1111.
  - ALUOp enum: ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_I.
  - Decode function.
- One sub-module: alu_dec_skid, the generic 2-slot valid/ready skid buffer parameterized on payload width. The top instantiates it with payload {Operation, OutTag[, illegal]}.

## Test plan
- Reset mid-stream, with both slots full and reset=1 for 1 cycle: out_valid=0, in_ready=1, Operation=0000 immediately, and the next accepted request is the first one seen at the output.
- Streaming with out_ready=1, five back-to-back requests: (10,000,0000000), (10,000,0100000), (10,111,0000000), (10,110,0000000), (01,000,x) with tags 1..5 produce 0010, 0110, 0000, 0001, 1000 one cycle later, in order.
- Backpressure: hold out_ready=0 while sending 3 requests. Only 2 are accepted, in_ready drops after the second, and `Operation` is held stable. Release out_ready: outputs drain in tag order with no loss or duplicate.
- Simultaneous transfer: with out_valid=1 and SKID empty, assert in_valid and out_ready in the same cycle. OUT is replaced by the new tag and out_valid stays 1.
- Unsupported encodings: (10,001,0000000), (01,001,x) and (10,000,0000001) produce Operation=1111. With ALU_DEC_ILLEGAL_EN, `Illegal` rises on the first accept and stays 1 until reset.
- I-type: (11,000,0100000) produces 0010, because Funct7 is ignored for ALUOp 11. Load/store (00,101,1111111) produces 0010.
